// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the next-PC unit.
//   pc_state_e      : exception-entry FSM states (RUN, EXC)
//   PC_VEC_BASE_DEF : default value of exception vector 0
//   PC_RESET_PC_DEF : default PC after reset
//   pc_sel_w()      : width of the next-PC select for N_SRC + N_VEC choices
//   pc_code_w()     : width of the exception code for N_VEC vectors
package pc_pkg;

  typedef enum logic {
    RUN = 1'b0,
    EXC = 1'b1
  } pc_state_e;

  localparam int PC_VEC_BASE_DEF = 253;
  localparam int PC_RESET_PC_DEF = 0;

  // At least one bit, so a single-choice configuration still has a port.
  function automatic int pc_sel_w(input int n_src, input int n_vec);
    return (n_src + n_vec > 1) ? $clog2(n_src + n_vec) : 1;
  endfunction

  function automatic int pc_code_w(input int n_vec);
    return (n_vec > 1) ? $clog2(n_vec) : 1;
  endfunction

endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux -- combinational next-PC selector.
//   sel      : select; 0..N_SRC-1 picks a datapath source,
//              N_SRC..N_SRC+N_VEC-1 picks constant vector VEC_BASE+(sel-N_SRC)
//   src_bus  : packed sources, source i at [i*WIDTH +: WIDTH]
//   next_val : selected value (zero when sel is out of range)
//   sel_oor  : sel does not name any source or vector
module pc_src_mux
  import pc_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int N_SRC    = 5,
  parameter  int N_VEC    = 3,
  parameter  int VEC_BASE = PC_VEC_BASE_DEF,
  localparam int SEL_W    = pc_sel_w(N_SRC, N_VEC)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] src_bus,
  output logic [WIDTH-1:0]       next_val,
  output logic                   sel_oor
);

  logic [WIDTH-1:0] src_arr [N_SRC];

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign src_arr[gi] = src_bus[gi*WIDTH +: WIDTH];
  end

  // Explicit compare loops keep the select safe when N_SRC+N_VEC is not
  // a power of two: unmatched codes simply leave sel_oor set.
  always_comb begin
    next_val = '0;
    sel_oor  = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        next_val = src_arr[i];
        sel_oor  = 1'b0;
      end
    end
    for (int k = 0; k < N_VEC; k++) begin
      if (sel == SEL_W'(N_SRC + k)) begin
        next_val = WIDTH'(VEC_BASE + k);
        sel_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit -- program counter register with next-PC selection,
// conditional/unconditional write control and one-step exception entry.
//   clk, reset    : clock (rising edge), asynchronous active-high reset
//   sel, src_bus  : next-PC select and packed datapath sources
//   pc_write      : unconditional PC update
//   pc_write_cond : PC update qualified by cond_flag
//   exc_req       : exception request (level); exc_code picks the vector
//   pc, epc       : program counter and exception PC registers
//   exc_busy      : high during the single EXC cycle
//   sel_err       : one-cycle pulse after an update with out-of-range sel
//   align_err     : one-cycle pulse after a suppressed misaligned update
// Build option: define PC_ALIGN_CHECK_EN to enable the alignment check;
// without it align_err is constant 0.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int N_SRC    = 5,
  parameter  int N_VEC    = 3,
  parameter  int VEC_BASE = PC_VEC_BASE_DEF,
  parameter  int RESET_PC = PC_RESET_PC_DEF,
  localparam int SEL_W    = pc_sel_w(N_SRC, N_VEC),
  localparam int CODE_W   = pc_code_w(N_VEC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] src_bus,
  input  logic                   pc_write,
  input  logic                   pc_write_cond,
  input  logic                   cond_flag,
  input  logic                   exc_req,
  input  logic [CODE_W-1:0]      exc_code,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       epc,
  output logic                   exc_busy,
  output logic                   sel_err,
  output logic                   align_err
);

  // The highest vector must be representable in WIDTH bits.
  if (WIDTH < 63) begin : g_vec_fit
    if ((longint'(VEC_BASE) + longint'(N_VEC) - 1) >= (longint'(1) << WIDTH)) begin : g_vec_overflow
      $error("pc_next_unit: VEC_BASE+N_VEC-1 does not fit in WIDTH bits");
    end
  end

  pc_state_e        state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, epc_reg;
  logic             sel_err_reg;
  logic [WIDTH-1:0] next_val, exc_vec;
  logic             sel_oor, upd, align_bad;

  pc_src_mux #(
    .WIDTH    (WIDTH),
    .N_SRC    (N_SRC),
    .N_VEC    (N_VEC),
    .VEC_BASE (VEC_BASE)
  ) u_mux (
    .sel      (sel),
    .src_bus  (src_bus),
    .next_val (next_val),
    .sel_oor  (sel_oor)
  );

  assign upd = pc_write | (pc_write_cond & cond_flag);

  // Codes beyond the last vector clamp to the last vector.
  always_comb begin
    exc_vec = WIDTH'(VEC_BASE + N_VEC - 1);
    if (int'(exc_code) < N_VEC) begin
      exc_vec = WIDTH'(VEC_BASE) + WIDTH'(exc_code);
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_reg;

  // Only datapath sources are checked; vectors are exempt.
  assign align_bad = (int'(sel) < N_SRC) && (next_val[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      align_err_reg <= 1'b0;
    end else begin
      align_err_reg <= (state_reg == RUN) && !exc_req && upd && !sel_oor && align_bad;
    end
  end

  assign align_err = align_err_reg;
`else
  assign align_bad = 1'b0;
  assign align_err = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: EXC always lasts exactly one cycle.
  always_comb begin
    state_next = RUN;
    if (state_reg == RUN && exc_req) begin
      state_next = EXC;
    end
  end

  // FSM outputs
  always_comb begin
    exc_busy = (state_reg == EXC);
  end

  // PC / EPC / error registers. In EXC every request is ignored, so an
  // exception arriving there is dropped rather than nested.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= WIDTH'(RESET_PC);
      epc_reg     <= '0;
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= 1'b0;
      if (state_reg == RUN) begin
        if (exc_req) begin
          epc_reg <= pc_reg;
          pc_reg  <= exc_vec;
        end else if (upd) begin
          if (sel_oor) begin
            sel_err_reg <= 1'b1;
          end else if (!align_bad) begin
            pc_reg <= next_val;
          end
        end
      end
    end
  end

  assign pc      = pc_reg;
  assign epc     = epc_reg;
  assign sel_err = sel_err_reg;

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

  logic         clk = 1'b0;
  logic         reset;

  // default configuration: N_SRC=5, N_VEC=3
  logic [2:0]   sel;
  logic [159:0] src_bus;
  logic         pc_write, pc_write_cond, cond_flag, exc_req;
  logic [1:0]   exc_code;
  logic [31:0]  pc, epc;
  logic         exc_busy, sel_err, align_err;

  // reduced configuration: N_SRC=4, N_VEC=2 (codes 6 and 7 out of range)
  logic [2:0]   s_sel;
  logic [127:0] s_src;
  logic         s_pw, s_pwc, s_cf, s_exc;
  logic [0:0]   s_code;
  logic [31:0]  s_pc, s_epc;
  logic         s_busy, s_sel_err, s_align_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_next_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .sel           (sel),
    .src_bus       (src_bus),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_flag     (cond_flag),
    .exc_req       (exc_req),
    .exc_code      (exc_code),
    .pc            (pc),
    .epc           (epc),
    .exc_busy      (exc_busy),
    .sel_err       (sel_err),
    .align_err     (align_err)
  );

  pc_next_unit #(.N_SRC(4), .N_VEC(2)) u_small (
    .clk           (clk),
    .reset         (reset),
    .sel           (s_sel),
    .src_bus       (s_src),
    .pc_write      (s_pw),
    .pc_write_cond (s_pwc),
    .cond_flag     (s_cf),
    .exc_req       (s_exc),
    .exc_code      (s_code),
    .pc            (s_pc),
    .epc           (s_epc),
    .exc_busy      (s_busy),
    .sel_err       (s_sel_err),
    .align_err     (s_align_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  // advance one clock and sample 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    sel = 3'd0; src_bus = '0; pc_write = 1'b1; pc_write_cond = 1'b0;
    cond_flag = 1'b0; exc_req = 1'b0; exc_code = 2'd0;
    src_bus[0*32 +: 32] = 32'h40;
    s_sel = 3'd0; s_src = '0; s_pw = 1'b0; s_pwc = 1'b0; s_cf = 1'b0;
    s_exc = 1'b0; s_code = 1'b0;

    // reset holds pc at RESET_PC even with pc_write active
    repeat (2) step();
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_busy", {31'd0, exc_busy}, 32'd0);
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);
    check("rst_align_err", {31'd0, align_err}, 32'd0);
    reset = 1'b0;
    step();
    check("first_upd", pc, 32'h40);
    check("small_idle_pc", s_pc, 32'h0);

    // constant vectors
    sel = 3'd5; step(); check("vec0", pc, 32'd253);
    sel = 3'd7; step(); check("vec2", pc, 32'd255);
    sel = 3'd6; step(); check("vec1", pc, 32'd254);

    // conditional write
    pc_write = 1'b0; pc_write_cond = 1'b1; cond_flag = 1'b0;
    sel = 3'd1; src_bus[1*32 +: 32] = 32'h100;
    step(); check("cond_false", pc, 32'd254);
    cond_flag = 1'b1;
    step(); check("cond_true", pc, 32'h100);
    pc_write_cond = 1'b0; cond_flag = 1'b0;

    // exception entry beats a simultaneous update
    pc_write = 1'b1; sel = 3'd0; src_bus[0*32 +: 32] = 32'h200;
    step(); check("pc_200", pc, 32'h200);
    check("no_sel_err", {31'd0, sel_err}, 32'd0);
    src_bus[0*32 +: 32] = 32'h300;
    exc_req = 1'b1; exc_code = 2'd1;
    step();
    check("exc_pc", pc, 32'd254);
    check("exc_epc", epc, 32'h200);
    check("exc_busy", {31'd0, exc_busy}, 32'd1);
    exc_code = 2'd2;  // second request and write while in EXC: dropped
    step();
    check("exc_drop_pc", pc, 32'd254);
    check("exc_drop_epc", epc, 32'h200);
    check("exc_busy_off", {31'd0, exc_busy}, 32'd0);
    exc_req = 1'b0; pc_write = 1'b0;
    step(); check("post_exc_pc", pc, 32'd254);

    // out-of-range exception code clamps to the last vector
    exc_req = 1'b1; exc_code = 2'd3;
    step();
    check("clamp_pc", pc, 32'd255);
    check("clamp_epc", epc, 32'd254);
    exc_req = 1'b0;
    step(); check("clamp_busy_off", {31'd0, exc_busy}, 32'd0);

    // misaligned source value
    pc_write = 1'b1; sel = 3'd0; src_bus[0*32 +: 32] = 32'h102;
    step();
`ifdef PC_ALIGN_CHECK_EN
    check("align_pc", pc, 32'd255);
    check("align_err", {31'd0, align_err}, 32'd1);
`else
    check("align_pc", pc, 32'h102);
    check("align_err", {31'd0, align_err}, 32'd0);
`endif
    pc_write = 1'b0;
    step(); check("align_err_off", {31'd0, align_err}, 32'd0);

    // out-of-range select on the reduced configuration
    s_pw = 1'b1; s_sel = 3'd0; s_src[0*32 +: 32] = 32'h80;
    step(); check("s_pc_80", s_pc, 32'h80);
    s_sel = 3'd7;
    step();
    check("s_oor_pc", s_pc, 32'h80);
    check("s_sel_err", {31'd0, s_sel_err}, 32'd1);
    s_pw = 1'b0;
    step(); check("s_sel_err_off", {31'd0, s_sel_err}, 32'd0);
    s_pw = 1'b1; s_sel = 3'd5;
    step(); check("s_vec1", s_pc, 32'd254);
    s_pw = 1'b0; s_pwc = 1'b1; s_cf = 1'b0; s_sel = 3'd6;
    step(); check("s_no_upd_no_err", {31'd0, s_sel_err}, 32'd0);
    s_pwc = 1'b0;

    // asynchronous reset in the middle of EXC
    exc_req = 1'b1; exc_code = 2'd0;
    step();
    check("exc2_pc", pc, 32'd253);
    check("exc2_busy", {31'd0, exc_busy}, 32'd1);
    exc_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_epc", epc, 32'h0);
    check("async_rst_busy", {31'd0, exc_busy}, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("after_rst_pc", pc, 32'h0);
    check("after_rst_busy", {31'd0, exc_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised successor to the PC source selector.
- Selects the next PC from N_SRC packed datapath sources or N_VEC constant exception vectors. Holds the program counter register.
- Implements the conditional and unconditional PC write controls.
- Runs a small exception-entry state machine that captures the EPC and vectors the PC in one atomic step.
- Sits between the ALU/ALUOut/instruction/EPC datapath and the instruction memory address port.

Parameters:
- WIDTH, 32, PC and source width in bits
- N_SRC, 5, number of datapath sources on src_bus
- N_VEC, 3, number of constant vectors; vector k = VEC_BASE + k
- VEC_BASE, 253, value of vector 0
- RESET_PC, 0, PC value after reset
- SEL_W, $clog2(N_SRC+N_VEC), width of sel (derived, not overridable)

Ports:
- clk, input, 1, system clock, rising edge
- reset, input, 1, asynchronous active-high reset
- sel, input, SEL_W, next-PC source select
- src_bus, input, N_SRC*WIDTH, packed sources; source i occupies bits [i*WIDTH +: WIDTH]
- pc_write, input, 1, unconditional PC update
- pc_write_cond, input, 1, PC update qualified by cond_flag
- cond_flag, input, 1, branch condition (ALU zero or equivalent)
- exc_req, input, 1, exception request, level sampled
- exc_code, input, $clog2(N_VEC), vector index for the exception
- pc, output, WIDTH, current PC register
- epc, output, WIDTH, exception PC register
- exc_busy, output, 1, high while the FSM is in EXC
- sel_err, output, 1, registered one-cycle pulse for an out-of-range select
- align_err, output, 1, misaligned next-PC flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous, active-high.
- Reset values: pc=RESET_PC, epc=0, exc_busy=0, sel_err=0, align_err=0, state=RUN.
- next_val (combinational):
  - sel < N_SRC: source slice sel.
  - N_SRC <= sel < N_SRC+N_VEC: VEC_BASE + (sel - N_SRC), zero-extended to WIDTH.
  - Otherwise out of range.
- upd = pc_write | (pc_write_cond & cond_flag).
- FSM has two states, RUN and EXC.
- RUN:
  - If exc_req=1: epc <= pc; pc <= VEC_BASE + exc_code; go to EXC. exc_req has priority over upd and sel. An exc_code >= N_VEC clamps to N_VEC-1.
  - Else if upd and sel is in range: pc <= next_val.
  - Else if upd and sel is out of range: pc holds and sel_err pulses high the next cycle.
  - Else pc holds.
- EXC:
  - Lasts exactly one cycle. exc_busy=1.
  - pc_write, pc_write_cond and exc_req are ignored. No nesting: an exception arriving here is dropped.
  - Returns to RUN unconditionally.
- Latency: every PC change is visible on pc one cycle after the sampling edge. epc is visible the cycle after exception entry.
- sel_err is only generated when upd=1 in RUN. It is never asserted in the cycle following reset release.
- Reset asserted mid-EXC: immediate return to reset values; the partial exception leaves no trace.
- Vector arithmetic is done in WIDTH bits. VEC_BASE+N_VEC-1 must fit in WIDTH; a static assertion is required.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - In RUN, an upd whose in-range next_val has bits [1:0] != 0 is suppressed (pc holds).
  - align_err pulses for one cycle.
  - Vector values are exempt from the check.
- Undefined: no alignment check; align_err is tied to 0.

Decomposition:
- Shared package (pc_pkg) holds:
  - state enum (RUN, EXC)
  - default VEC_BASE and RESET_PC constants
  - an SEL_W helper function
- Natural sub-module: pc_src_mux. It is the combinational next_val selector with an out-of-range flag, parametrised by WIDTH/N_SRC/N_VEC/VEC_BASE.
- The FSM and registers stay in pc_next_unit.

Test Plan:
- Reset with pc_write=1, sel=0, src0=0x40: pc stays 0 during reset; after release, the next edge gives pc=0x40.
- sel=5 (vector 0) with pc_write=1 -> pc=253. sel=7 -> pc=255.
- pc_write_cond=1, cond_flag=0, sel=1, src1=0x100 -> pc unchanged. With cond_flag=1 -> pc=0x100.
- pc=0x200, exc_req=1, exc_code=1, pc_write=1, sel=0 -> pc=254, epc=0x200, exc_busy=1 for one cycle. A second exc_req in that cycle is ignored.
- Override N_SRC=4, N_VEC=2 (SEL_W=3), sel=7, pc_write=1 -> pc holds, sel_err pulses one cycle.
- With PC_ALIGN_CHECK_EN defined: sel=0, src0=0x102, pc_write=1 -> pc holds, align_err=1. Without the macro: pc=0x102, align_err=0.
